// File: rtl/calc_pkg.sv
// Shared opcode encodings, FSM state type and error-trap helper for the shared calculator
// datapath.
package calc_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV = 3'd3;
  localparam logic [OP_W-1:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} calc_state_t;

  // Requests that must never reach the calculator: x/0, x%0 and undefined opcodes.
  function automatic logic is_trap(input logic [OP_W-1:0] op, input logic opb_zero);
    return (((op == OP_DIV) || (op == OP_MOD)) && opb_zero) || (op > OP_MOD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, searching in wrap order.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    // Upper segment [ptr, NUM_REQ) has priority over the wrapped segment [0, ptr).
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one external integer calculator between NUM_REQ requesters with round-robin grant,
// a fixed-latency issue window and a tagged response channel.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned CALC_LAT = 1,
  parameter int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_opa,
  input  logic [DATA_W*NUM_REQ-1:0] req_opb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [OP_W-1:0]           calc_operation,
  output logic [DATA_W-1:0]         calc_opa,
  output logic [DATA_W-1:0]         calc_opb,
  input  logic [DATA_W-1:0]         calc_result
);

  localparam int unsigned CNT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

  calc_state_t state_q, state_d;

  logic [ID_W-1:0]    ptr_q, ptr_next, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [CNT_W-1:0]   cnt_q;
  logic [OP_W-1:0]    op_q;
  logic [DATA_W-1:0]  opa_q, opb_q, data_q;
  logic [ID_W-1:0]    id_q;
  logic               err_q;

  logic [OP_W-1:0]   op_arr  [NUM_REQ];
  logic [DATA_W-1:0] opa_arr [NUM_REQ];
  logic [DATA_W-1:0] opb_arr [NUM_REQ];
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_opa, sel_opb;
  logic              accept, trap;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i]  = req_op[i*OP_W +: OP_W];
    assign opa_arr[i] = req_opa[i*DATA_W +: DATA_W];
    assign opb_arr[i] = req_opb[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  assign sel_op   = op_arr[gnt_idx];
  assign sel_opa  = opa_arr[gnt_idx];
  assign sel_opb  = opb_arr[gnt_idx];
  assign accept   = (state_q == IDLE) && (|gnt);
  assign trap     = is_trap(sel_op, sel_opb == '0);
  assign ptr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = trap ? RESP : EXEC;
      EXEC:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == IDLE) ? gnt : '0;
    rsp_valid      = (state_q == RESP);
    rsp_id         = id_q;
    rsp_data       = data_q;
    rsp_err        = err_q;
    calc_operation = op_q;
    calc_opa       = opa_q;
    calc_opb       = opb_q;
  end

  // Calculator operand registers are only written on a clean issue, so a trapped request
  // leaves the previous operation on the calculator inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      id_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        ptr_q <= ptr_next;
        id_q  <= gnt_idx;
        if (trap) begin
          err_q  <= 1'b1;
          data_q <= '0;
        end else begin
          op_q  <= sel_op;
          opa_q <= sel_opa;
          opb_q <= sel_opb;
          cnt_q <= CNT_W'(CALC_LAT - 1);
        end
      end
      if (state_q == EXEC) begin
        if (cnt_q == '0) begin
          data_q <= calc_result;
          err_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

endmodule
